// File: rtl/t05_pkg.sv
// Shared encodings for the histogram SRAM command bus and the reader FSM.
package t05_pkg;

    localparam logic [1:0] SRAM_READ  = 2'd0;
    localparam logic [1:0] SRAM_WRITE = 2'd1;
    localparam logic [1:0] SRAM_IDLE  = 2'd3;

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] REQ     = 4'd1;
    localparam logic [3:0] WAIT    = 4'd2;
    localparam logic [3:0] CAPTURE = 4'd3;
    localparam logic [3:0] CLEAR   = 4'd4;
    localparam logic [3:0] CHECK   = 4'd5;
    localparam logic [3:0] EMIT    = 4'd6;
    localparam logic [3:0] NEXT    = 4'd7;
    localparam logic [3:0] DONE    = 4'd8;

endpackage

// File: rtl/t05_hist_reader_if.sv
// (character, count) pair stream from the histogram reader to the tree/sort stage.
interface t05_hist_reader_if;

    logic [7:0]  out_char;
    logic [31:0] out_count;
    logic        out_valid;
    logic        out_ready;

    modport master (output out_char, output out_count, output out_valid, input out_ready);
    modport slave  (input out_char, input out_count, input out_valid, output out_ready);

endinterface

// File: rtl/t05_sram_rd_port.sv
// Read-latency counter and capture register for one SRAM read transaction.
module t05_sram_rd_port #(
    parameter int unsigned READ_LAT = 3
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        req_i,
    input  logic        wait_i,
    input  logic        capture_i,
    input  logic [31:0] sram_i,
    output logic        rd_done_o,
    output logic [31:0] data_o
);

    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;

    always_comb begin
        cnt_d  = cnt_q;
        data_d = data_q;
        if (req_i) begin
            cnt_d = 3'd0;
        end else if (wait_i) begin
            cnt_d = cnt_q + 3'd1;
        end
        if (capture_i) begin
            data_d = sram_i;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q  <= 3'd0;
            data_q <= 32'd0;
        end else begin
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

    // Last WAIT cycle: the next state may capture sram_i.
    assign rd_done_o = wait_i && (cnt_q == 3'(READ_LAT - 1));
    assign data_o    = data_q;

endmodule

// File: rtl/t05_hist_reader.sv
// Scans the 256-entry histogram SRAM, streams non-zero (char, count) pairs and checks the total.
module t05_hist_reader #(
    parameter logic [3:0]  ENABLE_STATE  = 4'd2,
    parameter int unsigned READ_LAT      = 3,
    parameter bit          CLEAR_ON_READ = 1'b1
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic [3:0]                en_state,
    input  logic [31:0]               total_in,
    input  logic [31:0]               sram_in,
    output logic [7:0]                hist_addr,
    output logic [31:0]               sram_out,
    output logic [1:0]                wr_r_en,
    output logic [8:0]                sym_cnt,
    output logic [31:0]               sum,
    output logic                      mismatch,
    output logic                      done,
    t05_hist_reader_if.master         out_if
);

    import t05_pkg::*;

    logic [3:0]  state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  hist_addr_q, hist_addr_d;
    logic [1:0]  wr_r_en_q, wr_r_en_d;
    logic [7:0]  out_char_q, out_char_d;
    logic [31:0] out_count_q, out_count_d;
    logic        out_valid_q, out_valid_d;
    logic [8:0]  sym_cnt_q, sym_cnt_d;
    logic [31:0] sum_q, sum_d;
    logic        mismatch_q, mismatch_d;
    logic        done_q, done_d;

    logic        run;
    logic        rd_done;
    logic [31:0] data_reg;

    assign run = (en_state == ENABLE_STATE);

    t05_sram_rd_port #(
        .READ_LAT (READ_LAT)
    ) u_rd_port (
        .clk       (clk),
        .nrst      (nrst),
        .req_i     (state_q == REQ),
        .wait_i    (state_q == WAIT),
        .capture_i (state_q == CAPTURE),
        .sram_i    (sram_in),
        .rd_done_o (rd_done),
        .data_o    (data_reg)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        hist_addr_d = hist_addr_q;
        wr_r_en_d   = wr_r_en_q;
        out_char_d  = out_char_q;
        out_count_d = out_count_q;
        out_valid_d = out_valid_q;
        sym_cnt_d   = sym_cnt_q;
        sum_d       = sum_q;
        mismatch_d  = mismatch_q;
        done_d      = done_q;

        // Abort: a partially scanned (and partially cleared) table is left as-is.
        if (!run && state_q != IDLE && state_q != DONE) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            wr_r_en_d   = SRAM_IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    wr_r_en_d = SRAM_IDLE;
                    if (run) begin
                        sym_cnt_d   = 9'd0;
                        sum_d       = 32'd0;
                        mismatch_d  = 1'b0;
                        done_d      = 1'b0;
                        addr_d      = 8'd0;
                        hist_addr_d = 8'd0;
                        wr_r_en_d   = SRAM_READ;
                        state_d     = REQ;
                    end
                end
                REQ: begin
                    wr_r_en_d = SRAM_IDLE;
                    state_d   = WAIT;
                end
                WAIT: begin
                    if (rd_done) begin
                        state_d = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (CLEAR_ON_READ) begin
                        hist_addr_d = addr_q;
                        wr_r_en_d   = SRAM_WRITE;
                        state_d     = CLEAR;
                    end else begin
                        state_d = CHECK;
                    end
                end
                CLEAR: begin
                    wr_r_en_d = SRAM_IDLE;
                    state_d   = CHECK;
                end
                CHECK: begin
                    wr_r_en_d = SRAM_IDLE;
                    if (data_reg != 32'd0) begin
                        out_char_d  = addr_q;
                        out_count_d = data_reg;
                        out_valid_d = 1'b1;
                        sum_d       = sum_q + data_reg;
                        sym_cnt_d   = sym_cnt_q + 9'd1;
                        state_d     = EMIT;
                    end else begin
                        state_d = NEXT;
                    end
                end
                EMIT: begin
                    if (out_if.out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = NEXT;
                    end
                end
                NEXT: begin
                    if (addr_q == 8'hFF) begin
                        done_d     = 1'b1;
                        mismatch_d = (sum_q != total_in);
                        state_d    = DONE;
                    end else begin
                        addr_d      = addr_q + 8'd1;
                        hist_addr_d = addr_q + 8'd1;
                        wr_r_en_d   = SRAM_READ;
                        state_d     = REQ;
                    end
                end
                DONE: begin
                    wr_r_en_d = SRAM_IDLE;
                    if (!run) begin
                        done_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    wr_r_en_d   = SRAM_IDLE;
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            addr_q      <= 8'd0;
            hist_addr_q <= 8'd0;
            wr_r_en_q   <= SRAM_IDLE;
            out_char_q  <= 8'd0;
            out_count_q <= 32'd0;
            out_valid_q <= 1'b0;
            sym_cnt_q   <= 9'd0;
            sum_q       <= 32'd0;
            mismatch_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            hist_addr_q <= hist_addr_d;
            wr_r_en_q   <= wr_r_en_d;
            out_char_q  <= out_char_d;
            out_count_q <= out_count_d;
            out_valid_q <= out_valid_d;
            sym_cnt_q   <= sym_cnt_d;
            sum_q       <= sum_d;
            mismatch_q  <= mismatch_d;
            done_q      <= done_d;
        end
    end

    assign hist_addr        = hist_addr_q;
    assign sram_out         = 32'd0;
    assign wr_r_en          = wr_r_en_q;
    assign sym_cnt          = sym_cnt_q;
    assign sum              = sum_q;
    assign mismatch         = mismatch_q;
    assign done             = done_q;
    assign out_if.out_char  = out_char_q;
    assign out_if.out_count = out_count_q;
    assign out_if.out_valid = out_valid_q;

endmodule

// File: tb/tb_t05_hist_reader.sv
// Scoreboard bench for t05_hist_reader: behavioural SRAM, table-level reference model, pair monitor.
module tb_t05_hist_reader;

    import t05_pkg::*;

    localparam int unsigned RL  = 3;
    localparam logic [3:0]  EN  = 4'd2;
    localparam bit          COR = 1'b1;

    logic        clk = 1'b0;
    logic        nrst;
    logic [3:0]  en_state;
    logic [31:0] total_in;
    logic [31:0] sram_in;
    logic [7:0]  hist_addr;
    logic [31:0] sram_out;
    logic [1:0]  wr_r_en;
    logic [8:0]  sym_cnt;
    logic [31:0] sum;
    logic        mismatch;
    logic        done;

    t05_hist_reader_if bus ();

    t05_hist_reader #(
        .ENABLE_STATE  (EN),
        .READ_LAT      (RL),
        .CLEAR_ON_READ (COR)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .en_state (en_state),
        .total_in (total_in),
        .sram_in  (sram_in),
        .hist_addr(hist_addr),
        .sram_out (sram_out),
        .wr_r_en  (wr_r_en),
        .sym_cnt  (sym_cnt),
        .sum      (sum),
        .mismatch (mismatch),
        .done     (done),
        .out_if   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem     [256];
    logic [31:0] ref_tbl [256];
    logic [39:0] exp_q [$];
    logic [31:0] exp_sum;
    int          exp_sym;
    int          rd_count;
    int          rd_left;
    logic [7:0]  rd_addr;
    int          ready_mode;
    int          stall;
    int          pass_cnt;
    int          total_cnt;
    logic        stalled;
    logic [39:0] held;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // SRAM: garbage on sram_in until READ_LAT cycles after the request, then the entry.
    initial begin
        rd_left  = 0;
        rd_count = 0;
        forever begin
            @(posedge clk);
            if (!nrst) begin
                rd_left = 0;
            end else begin
                if (wr_r_en == SRAM_WRITE) mem[hist_addr] = sram_out;
                if (rd_left > 0) begin
                    rd_left--;
                    if (rd_left == 0) sram_in <= mem[rd_addr];
                end
                if (wr_r_en == SRAM_READ) begin
                    rd_count++;
                    rd_addr = hist_addr;
                    rd_left = RL - 1;
                    if (rd_left == 0) sram_in <= mem[hist_addr];
                    else sram_in <= $urandom;
                end
            end
        end
    end

    // Downstream ready: 0 tied high, 1 random, 2 stall 10 cycles per pair, else held low.
    initial begin
        stall        = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bus.out_valid && !bus.out_ready) stall++;
            else stall = 0;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                2:       bus.out_ready = (stall >= 10);
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every transfer and checks stability while stalled.
    initial begin
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (!nrst || en_state != EN) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("stall_valid", 40'(bus.out_valid), 40'd1);
                    check("stall_pair", {bus.out_char, bus.out_count}, held);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        total_cnt++;
                        $display("FAIL unexpected_pair: got %0h expected none",
                                 {bus.out_char, bus.out_count});
                    end else begin
                        check("pair", {bus.out_char, bus.out_count}, exp_q.pop_front());
                    end
                end
                stalled = bus.out_valid && !bus.out_ready;
                held    = {bus.out_char, bus.out_count};
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_scan(input logic [31:0] tot, input int rmode, input bit load);
        logic seen;
        if (load) for (int a = 0; a < 256; a++) mem[a] = ref_tbl[a];
        exp_q.delete();
        exp_sum = 32'd0;
        exp_sym = 0;
        for (int a = 0; a < 256; a++) begin
            if (ref_tbl[a] != 32'd0) begin
                exp_q.push_back({8'(a), ref_tbl[a]});
                exp_sum = exp_sum + ref_tbl[a];
                exp_sym++;
            end
        end
        total_in   = tot;
        ready_mode = rmode;
        rd_count   = 0;
        en_state   = EN;
        seen       = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = (wr_r_en == SRAM_READ);
        end
        check("first_read_seen", 40'(seen), 40'd1);
        check("first_read_addr", 40'(hist_addr), 40'd0);
    endtask

    task automatic finish_scan(input logic [31:0] tot);
        int nz;
        logic [8:0] sym_hold;
        for (int i = 0; i < 10000 && !done; i++) tick();
        check("done", 40'(done), 40'd1);
        check("sym_cnt", 40'(sym_cnt), 40'(exp_sym));
        check("sum", 40'(sum), 40'(exp_sum));
        check("mismatch", 40'(mismatch), 40'(exp_sum != tot));
        check("pairs_left", 40'(exp_q.size()), 40'd0);
        check("reads_issued", 40'(rd_count), 40'd256);
        nz = 0;
        for (int a = 0; a < 256; a++) if (mem[a] != 32'd0) nz++;
        check("mem_cleared", 40'(nz), 40'd0);
        sym_hold = 9'(exp_sym);
        en_state = 4'd0;
        tick();
        tick();
        check("done_cleared", 40'(done), 40'd0);
        check("sym_cnt_held", 40'(sym_cnt), 40'(sym_hold));
        check("idle_cmd", 40'(wr_r_en), 40'(SRAM_IDLE));
    endtask

    task automatic clear_ref();
        for (int a = 0; a < 256; a++) ref_tbl[a] = 32'd0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_wr_r_en"}, 40'(wr_r_en), 40'(SRAM_IDLE));
        check({tag, "_hist_addr"}, 40'(hist_addr), 40'd0);
        check({tag, "_out_valid"}, 40'(bus.out_valid), 40'd0);
        check({tag, "_out_pair"}, {bus.out_char, bus.out_count}, 40'd0);
        check({tag, "_done"}, 40'(done), 40'd0);
        check({tag, "_sym_cnt"}, 40'(sym_cnt), 40'd0);
        check({tag, "_sum"}, 40'(sum), 40'd0);
        check({tag, "_mismatch"}, 40'(mismatch), 40'd0);
        check({tag, "_sram_out"}, 40'(sram_out), 40'd0);
    endtask

    initial begin
        logic [31:0] tot;
        logic        seen;
        pass_cnt   = 0;
        total_cnt  = 0;
        nrst       = 1'b0;
        en_state   = 4'd0;
        total_in   = 32'd0;
        sram_in    = 32'd0;
        ready_mode = 0;
        clear_ref();
        for (int a = 0; a < 256; a++) mem[a] = 32'd0;
        tick();
        tick();
        reset_checks("reset");
        @(negedge clk);
        nrst = 1'b1;
        tick();

        // Basic table, ready tied high
        ref_tbl[8'h61] = 32'd5;
        ref_tbl[8'h62] = 32'd2;
        ref_tbl[8'h1A] = 32'd1;
        start_scan(32'd8, 0, 1'b1);
        finish_scan(32'd8);

        // Same table, 10-cycle stall per pair
        start_scan(32'd8, 2, 1'b1);
        finish_scan(32'd8);

        // All-zero table, matching and non-matching total
        clear_ref();
        start_scan(32'd0, 0, 1'b1);
        finish_scan(32'd0);
        start_scan(32'd3, 0, 1'b1);
        finish_scan(32'd3);

        // Boundary addresses with sum wrap
        ref_tbl[8'h00] = 32'hFFFF_FFFF;
        ref_tbl[8'hFF] = 32'hFFFF_FFFF;
        start_scan(32'hFFFF_FFFE, 1, 1'b1);
        finish_scan(32'hFFFF_FFFE);

        // Random sparse tables, random ready, total sometimes off by one
        for (int t = 0; t < 2; t++) begin
            tot = 32'd0;
            for (int a = 0; a < 256; a++) begin
                ref_tbl[a] = ($urandom_range(0, 1) == 1) ? $urandom : 32'd0;
                tot = tot + ref_tbl[a];
            end
            tot = tot + 32'($urandom_range(0, 1));
            start_scan(tot, 1, 1'b1);
            finish_scan(tot);
        end

        // All 256 entries non-zero
        tot = 32'd0;
        for (int a = 0; a < 256; a++) begin
            ref_tbl[a] = $urandom_range(1, 1000);
            tot = tot + ref_tbl[a];
        end
        start_scan(tot, 1, 1'b1);
        finish_scan(tot);

        // Abort while presenting the pair at 0x40, then restart from address 0
        clear_ref();
        ref_tbl[8'h40] = 32'd9;
        ref_tbl[8'h80] = 32'd3;
        ref_tbl[8'hC0] = 32'd4;
        start_scan(32'd16, 3, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            tick();
            seen = bus.out_valid;
        end
        check("abort_emit_seen", 40'(seen), 40'd1);
        check("abort_emit_char", 40'(bus.out_char), 40'h40);
        en_state = 4'd0;
        tick();
        check("abort_valid", 40'(bus.out_valid), 40'd0);
        check("abort_cmd", 40'(wr_r_en), 40'(SRAM_IDLE));
        tick();
        tick();
        tick();
        check("abort_idle_cmd", 40'(wr_r_en), 40'(SRAM_IDLE));
        check("abort_idle_valid", 40'(bus.out_valid), 40'd0);
        check("abort_idle_done", 40'(done), 40'd0);
        exp_q.delete();
        for (int a = 0; a <= 8'h40; a++) ref_tbl[a] = 32'd0;
        start_scan(32'd7, 0, 1'b0);
        finish_scan(32'd7);

        // Asynchronous reset in the middle of a WAIT
        clear_ref();
        ref_tbl[8'h05] = 32'd11;
        ref_tbl[8'h10] = 32'd22;
        ref_tbl[8'h90] = 32'd33;
        start_scan(32'd66, 0, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            tick();
            seen = (sym_cnt == 9'd2) && (wr_r_en == SRAM_READ);
        end
        check("rst_prep_seen", 40'(seen), 40'd1);
        tick();
        #2;
        nrst = 1'b0;
        #1;
        reset_checks("midrst");
        exp_q.delete();
        en_state = 4'd0;
        @(negedge clk);
        nrst = 1'b1;
        tick();

        // Recovery scan after reset
        clear_ref();
        ref_tbl[8'h61] = 32'd5;
        ref_tbl[8'h62] = 32'd2;
        ref_tbl[8'h1A] = 32'd1;
        start_scan(32'd8, 1, 1'b1);
        finish_scan(32'd8);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
